shared_mem_arbiter: RTL and testbench

Two-master arbiter for the single-port on-chip shared memory. Two Avalon-MM masters (one per CPU) connect on the upstream side; the memory's single slave port connects on the downstream side. The arbiter serialises accesses with round-robin fairness and an optional lock for atomic read-modify-write sequences. It also suppresses accesses beyond the populated depth.

---
 rtl/shared_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Two-master round-robin arbiter with lock for a single-port shared memory.
// Out-of-range accesses are released without reaching the memory.
module shared_mem_arbiter #(
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BE_W      = 4,
   parameter int unsigned NUM_WORDS = 16380
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic              m0_lock,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic              m1_lock,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

   state_t state, state_next;

   logic              grant;
   logic              cmd_write;
   logic              cmd_oor;
   logic              last_grant;
   logic              lock_valid;
   logic              lock_owner;

   logic              req0, req1;
   logic              win;
   logic              win_id;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [BE_W-1:0]   sel_be;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_oor;
   logic              cur_lock;
   logic [DATA_W-1:0] rd_value;

   assign req0      = m0_read | m0_write;
   assign req1      = m1_read | m1_write;
   assign sel_write = win_id ? m1_write      : m0_write;
   assign sel_addr  = win_id ? m1_address    : m0_address;
   assign sel_be    = win_id ? m1_byteenable : m0_byteenable;
   assign sel_wdata = win_id ? m1_writedata  : m0_writedata;
   assign sel_oor   = 32'(sel_addr) >= NUM_WORDS;
   assign cur_lock  = grant ? m1_lock : m0_lock;
   assign rd_value  = cmd_oor ? '0 : mem_readdata;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Arbitration and next-state decode
   always_comb begin
      state_next = state;
      win        = 1'b0;
      win_id     = 1'b0;
      case (state)
         IDLE: begin
            if (lock_valid) begin
               // Non-owner is shut out for as long as the lock is held
               if (lock_owner ? req1 : req0) begin
                  win    = 1'b1;
                  win_id = lock_owner;
               end
            end else if (req0 && req1) begin
               win    = 1'b1;
               win_id = ~last_grant;
            end else if (req0) begin
               win    = 1'b1;
               win_id = 1'b0;
            end else if (req1) begin
               win    = 1'b1;
               win_id = 1'b1;
            end
            if (win) state_next = ACCESS;
         end
         ACCESS:  state_next = cmd_write ? IDLE : RDATA;
         RDATA:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Command capture, memory port, lock tracking and read return
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant            <= 1'b0;
         cmd_write        <= 1'b0;
         cmd_oor          <= 1'b0;
         last_grant       <= 1'b1;
         lock_valid       <= 1'b0;
         lock_owner       <= 1'b0;
         m0_waitrequest   <= 1'b1;
         m1_waitrequest   <= 1'b1;
         m0_readdata      <= '0;
         m1_readdata      <= '0;
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
         mem_address      <= '0;
         mem_byteenable   <= '0;
         mem_writedata    <= '0;
         mem_chipselect   <= 1'b0;
         mem_write        <= 1'b0;
         mem_clken        <= 1'b0;
      end else begin
         mem_clken        <= 1'b1;
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
         mem_chipselect   <= 1'b0;
         mem_write        <= 1'b0;
         // Waitrequest registered from the decision that enters ACCESS
         m0_waitrequest   <= ~(state_next == ACCESS && win_id == 1'b0);
         m1_waitrequest   <= ~(state_next == ACCESS && win_id == 1'b1);

         if (win) begin
            grant          <= win_id;
            cmd_write      <= sel_write;
            cmd_oor        <= sel_oor;
            mem_address    <= sel_addr;
            mem_byteenable <= sel_be;
            mem_writedata  <= sel_wdata;
            mem_chipselect <= ~sel_oor;
            mem_write      <= sel_write & ~sel_oor;
         end

         // Only the owner can reach ACCESS while locked, so this both sets and clears
         if (state == ACCESS) begin
            last_grant <= grant;
            lock_valid <= cur_lock;
            lock_owner <= grant;
         end

         if (state == RDATA) begin
            if (grant) begin
               m1_readdata      <= rd_value;
               m1_readdatavalid <= 1'b1;
            end else begin
               m0_readdata      <= rd_value;
               m0_readdatavalid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter with a byte-lane memory model.
module tb_shared_mem_arbiter;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      bit          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  t_read, t_write, t_lock;
   logic [13:0] t_addr [2];
   logic [3:0]  t_be [2];
   logic [31:0] t_wdata [2];

   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [13:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_readdata;

   logic [1:0]  wreq, rvalid;
   logic [31:0] rdd [2];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   glog[$];
   bit   both_low = 1'b0;
   bit   oor_watch = 1'b0;
   bit   cs_seen = 1'b0;
   bit [31:0] mem [int];

   assign wreq   = {m1_waitrequest, m0_waitrequest};
   assign rvalid = {m1_readdatavalid, m0_readdatavalid};
   assign rdd[0] = m0_readdata;
   assign rdd[1] = m1_readdata;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shared_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_read(t_read[0]), .m0_write(t_write[0]), .m0_address(t_addr[0]),
      .m0_byteenable(t_be[0]), .m0_writedata(t_wdata[0]), .m0_lock(t_lock[0]),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_read(t_read[1]), .m1_write(t_write[1]), .m1_address(t_addr[1]),
      .m1_byteenable(t_be[1]), .m1_writedata(t_wdata[1]), .m1_lock(t_lock[1]),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   // Single-port memory with one-cycle registered read
   always @(posedge clk) begin
      bit [31:0] cur;
      if (mem_clken && mem_chipselect) begin
         cur = mem.exists(int'(mem_address)) ? mem[int'(mem_address)] : 32'h0;
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) cur[8*b +: 8] = mem_writedata[8*b +: 8];
            mem[int'(mem_address)] = cur;
         end else begin
            mem_readdata <= cur;
         end
      end
   end

   // Monitor: read returns against the scoreboard, grant log, protocol flags
   always @(negedge clk) begin
      exp_t e;
      for (int m = 0; m < 2; m++) begin
         if (rvalid[m]) begin
            checks++;
            if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
               errors++;
               $display("FAIL rd_unexpected_m%0d: got readdatavalid data=%h, required no response", m, rdd[m]);
            end else begin
               if (m == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               if (rdd[m] !== e.data) begin
                  errors++;
                  $display("FAIL rd_data_m%0d: got %h, required %h", m, rdd[m], e.data);
               end
               if (e.lat) begin
                  checks++;
                  if (cyc - e.cyc != 3) begin
                     errors++;
                     $display("FAIL rd_latency_m%0d: got %0d cycles, required 3", m, cyc - e.cyc);
                  end
               end
            end
         end
      end
      if (!m0_waitrequest) glog.push_back(0);
      if (!m1_waitrequest) glog.push_back(1);
      if (!m0_waitrequest && !m1_waitrequest) both_low = 1'b1;
      if (oor_watch && mem_chipselect) cs_seen = 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Issue one command from master m and hold it until accepted
   task automatic cmd(input int m, input bit rd, input bit wr, input logic [13:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input bit lk,
                      input bit push, input logic [31:0] ex, input bit lat);
      int n = 0;
      exp_t e;
      t_read[m] = rd; t_write[m] = wr; t_addr[m] = a;
      t_be[m] = be; t_wdata[m] = wd; t_lock[m] = lk;
      if (push) begin
         e.data = ex; e.cyc = cyc; e.lat = lat;
         if (m == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(negedge clk);
      while (wreq[m] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (wreq[m]) begin
         checks++; errors++;
         $display("FAIL accept_timeout_m%0d: waitrequest still 1 after 200 cycles, required 0", m);
      end
      @(posedge clk);
      #1;
      t_read[m] = 1'b0; t_write[m] = 1'b0; t_lock[m] = 1'b0;
      @(negedge clk);
      chk($sformatf("wait_one_cycle_m%0d", m), 32'(wreq[m]), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() + q1.size()) != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      t_read = '0; t_write = '0; t_lock = '0;
      for (int i = 0; i < 2; i++) begin
         t_addr[i] = '0; t_be[i] = '0; t_wdata[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_cs", 32'(mem_chipselect), 32'd0);
      chk("rst_clken", 32'(mem_clken), 32'd0);
      chk("rst_addr", 32'(mem_address), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Contention from reset: 8 writes each, alternating grants starting with m0
      glog.delete();
      fork
         for (int i = 0; i < 8; i++) cmd(0, 0, 1, 14'(100 + i), 4'hF, 32'h1000 + i, 0, 0, 0, 0);
         for (int i = 0; i < 8; i++) cmd(1, 0, 1, 14'(200 + i), 4'hF, 32'h2000 + i, 0, 0, 0, 0);
      join
      chk("clken_after_rst", 32'(mem_clken), 32'd1);
      chk("cont_len", 32'(glog.size()), 32'd16);
      for (int i = 0; i < 16 && i < glog.size(); i++)
         chk($sformatf("cont_grant_%0d", i), 32'(glog[i]), 32'(i % 2));
      cmd(1, 1, 0, 14'd207, 4'hF, 0, 0, 1, 32'h2007, 0);
      drain();

      // Single write then read, with latency check
      cmd(0, 0, 1, 14'd5, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0);
      cmd(0, 1, 0, 14'd5, 4'hF, 0, 0, 1, 32'hDEADBEEF, 1);
      drain();

      // Byte lanes
      cmd(0, 0, 1, 14'd7, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0);
      cmd(0, 0, 1, 14'd7, 4'h2, 32'h00000000, 0, 0, 0, 0);
      cmd(0, 1, 0, 14'd7, 4'hF, 0, 0, 1, 32'hFFFF00FF, 0);
      drain();

      // Read with write treated as a write (no readdatavalid expected)
      cmd(1, 1, 1, 14'd8, 4'hF, 32'h0BADF00D, 0, 0, 0, 0);
      cmd(1, 1, 0, 14'd8, 4'hF, 0, 0, 1, 32'h0BADF00D, 0);
      drain();

      // Lock: m1 read-modify-write on address 10 holds m0 off
      glog.delete();
      fork
         begin
            cmd(1, 1, 0, 14'd10, 4'hF, 0, 1, 1, 32'h0, 0);
            repeat (4) @(negedge clk);
            cmd(1, 0, 1, 14'd10, 4'hF, 32'h1, 0, 0, 0, 0);
         end
         begin
            @(posedge clk);
            #1;
            cmd(0, 0, 1, 14'd20, 4'hF, 32'h55, 0, 0, 0, 0);
         end
      join
      chk("lock_len", 32'(glog.size()), 32'd3);
      if (glog.size() == 3) begin
         chk("lock_grant_0", 32'(glog[0]), 32'd1);
         chk("lock_grant_1", 32'(glog[1]), 32'd1);
         chk("lock_grant_2", 32'(glog[2]), 32'd0);
      end
      cmd(0, 1, 0, 14'd10, 4'hF, 0, 0, 1, 32'h1, 0);
      cmd(0, 1, 0, 14'd20, 4'hF, 0, 0, 1, 32'h55, 0);
      drain();

      // Out of range
      cmd(0, 0, 1, 14'd0, 4'hF, 32'hA5A5A5A5, 0, 0, 0, 0);
      oor_watch = 1'b1; cs_seen = 1'b0;
      cmd(0, 0, 1, 14'd16380, 4'hF, 32'h12345678, 0, 0, 0, 0);
      cmd(0, 1, 0, 14'd16380, 4'hF, 0, 0, 1, 32'h0, 0);
      drain();
      oor_watch = 1'b0;
      chk("oor_chipselect", 32'(cs_seen), 32'd0);
      cmd(0, 1, 0, 14'd0, 4'hF, 0, 0, 1, 32'hA5A5A5A5, 0);
      drain();

      // Reset during RDATA
      cmd(0, 1, 0, 14'd5, 4'hF, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      chk("mrst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("mrst_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("mrst_rvalid", 32'(rvalid), 32'd0);
      chk("mrst_m0_rdata", m0_readdata, 32'd0);
      chk("mrst_cs", 32'(mem_chipselect), 32'd0);
      chk("mrst_clken", 32'(mem_clken), 32'd0);
      chk("mrst_addr", 32'(mem_address), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(negedge clk);
      glog.delete();
      fork
         cmd(0, 0, 1, 14'd30, 4'hF, 32'h30, 0, 0, 0, 0);
         cmd(1, 0, 1, 14'd31, 4'hF, 32'h31, 0, 0, 0, 0);
      join
      chk("post_rst_len", 32'(glog.size()), 32'd2);
      if (glog.size() > 0) chk("post_rst_first", 32'(glog[0]), 32'd0);

      drain();
      chk("never_both_low", 32'(both_low), 32'd0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
